// File: rtl/arb_requester.sv
// Requester-side agent: queues burst lengths, requests the shared bus, and streams
// exactly len beats through while granted, then releases by ack pulse or request drop.
module arb_requester #(
    parameter  int DATA_WIDTH    = 32,
    parameter  int MAX_BURST     = 16,
    parameter  int DEPTH         = 4,
    parameter  int ARB_BLOCK_ACK = 1,
    localparam int LW            = $clog2(MAX_BURST + 1),
    localparam int AW            = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LW-1:0]         cmd_len,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  arb_request,
    input  logic                  arb_grant,
    output logic                  arb_acknowledge,
    output logic                  busy
);

    // state   | meaning
    // IDLE    | pop next command; zero-length commands are dropped here
    // REQ     | request raised, waiting for grant, no payload moves
    // XFER    | granted, payload passes through until rem reaches zero
    // RELEASE | request dropped (ack pulse on entry), wait for grant to clear
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_REL
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_rst_sync;
    logic            w_rst_n;
    logic [LW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [LW-1:0]   r_rem;
    logic            r_rel_first;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_beat;
    logic [LW-1:0]   w_head;

    // Reset asserts asynchronously everywhere but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign cmd_ready = w_rst_n && !w_full;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_beat    = (r_state == S_XFER) && arb_grant && s_valid && m_ready;
    assign m_data    = s_data;
    assign busy      = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_len;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_rel_first <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rel_first <= (w_state_next == S_REL) && (r_state != S_REL);
            if (w_pop && (w_head != '0)) begin
                r_rem <= w_head;
            end else if (w_beat) begin
                r_rem <= r_rem - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pop && (w_head != '0)) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (arb_grant) begin
                    w_state_next = S_XFER;
                end
            end
            S_XFER: begin
                // Losing grant mid-burst returns to REQ with rem untouched.
                if (!arb_grant) begin
                    w_state_next = S_REQ;
                end else if (w_beat && (r_rem == LW'(1))) begin
                    w_state_next = S_REL;
                end
            end
            S_REL: begin
                if (!arb_grant) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        arb_request     = 1'b0;
        arb_acknowledge = 1'b0;
        m_valid         = 1'b0;
        s_ready         = 1'b0;
        m_last          = 1'b0;
        case (r_state)
            S_REQ: begin
                arb_request = 1'b1;
            end
            S_XFER: begin
                arb_request = 1'b1;
                if (arb_grant) begin
                    m_valid = s_valid;
                    s_ready = m_ready;
                    m_last  = (r_rem == LW'(1));
                end
            end
            S_REL: begin
                arb_acknowledge = (ARB_BLOCK_ACK != 0) && r_rel_first;
            end
            default: begin
                arb_request = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: a scripted registered arbiter, an incrementing
// payload source and a scoreboard of expected beats filled as commands are accepted.
module tb_arb_requester;

    localparam int DW    = 32;
    localparam int MB    = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_len = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          m_last;
    logic          arb_request;
    logic          arb_grant = 1'b0;
    logic          arb_acknowledge;
    logic          busy;

    always #5 clk = ~clk;

    arb_requester #(
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MB),
        .DEPTH        (DEPTH),
        .ARB_BLOCK_ACK(1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_len        (cmd_len),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .arb_request    (arb_request),
        .arb_grant      (arb_grant),
        .arb_acknowledge(arb_acknowledge),
        .busy           (busy)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    beats = 0;
    int    acks = 0;
    int    src_idx = 0;
    int    exp_idx = 0;
    int    req_cnt = 0;
    int    arb_dly = 1;
    bit    arb_block = 1'b0;
    bit    settled = 1'b0;
    bit    took = 1'b0;
    bit    pushed = 1'b0;
    bit    toggle_ready = 1'b0;
    bit    saw_req = 1'b0;
    int    b0;
    int    a0;
    bit    ok;

    function automatic logic [DW-1:0] pay(int i);
        return 32'hA500_0000 + 32'(i);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd_grant();
        arb_grant = rst_n && !arb_block && (req_cnt >= arb_dly);
    endtask

    // Sample the cycle just after inputs settle, well before the next rising edge.
    task automatic settle();
        beat_t b;
        #1;
        pushed = 1'b0;
        took   = s_valid && s_ready;
        if (rst_n && cmd_valid && cmd_ready) begin
            pushed = 1'b1;
            for (int k = 0; k < int'(cmd_len); k++) begin
                b.data = pay(exp_idx);
                b.last = (k == int'(cmd_len) - 1);
                exp_q.push_back(b);
                exp_idx++;
            end
        end
        if (m_valid && m_ready) begin
            beats++;
            chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("beat_data", m_data, b.data);
                chk("beat_last", 32'(m_last), 32'(b.last));
            end
        end
        if (arb_acknowledge) acks++;
        if (arb_request) begin
            req_cnt++;
            saw_req = 1'b1;
        end else begin
            req_cnt = 0;
        end
        settled = 1'b1;
    endtask

    task automatic adv();
        if (!settled) settle();
        @(negedge clk);
        settled = 1'b0;
        if (took) src_idx++;
        s_data = pay(src_idx);
        if (toggle_ready) m_ready = ~m_ready;
        upd_grant();
    endtask

    task automatic push_cmd(int len);
        bit got;
        got = 1'b0;
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        for (int i = 0; i < 50; i++) begin
            settle();
            got = pushed;
            adv();
            if (got) break;
        end
        cmd_valid = 1'b0;
        chk("push_accepted", 32'(got), 1);
    endtask

    task automatic run_idle(int max, string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max; i++) begin
            settle();
            done = !busy;
            adv();
            if (done) break;
        end
        chk(tag, 32'(done), 1);
    endtask

    initial begin
        s_data  = pay(0);
        s_valid = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_request", 32'(arb_request), 0);
        chk("rst_ack", 32'(arb_acknowledge), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) adv();
        settle();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        adv();

        // len=3, arbiter grants two cycles after request
        arb_dly = 2;
        b0 = beats;
        a0 = acks;
        push_cmd(3);
        settle();
        chk("t1_req_latency0", 32'(arb_request), 0);
        chk("t1_busy", 32'(busy), 1);
        adv();
        settle();
        chk("t1_req_high", 32'(arb_request), 1);
        chk("t1_no_data_req0", 32'(m_valid), 0);
        adv();
        settle();
        chk("t1_no_data_req1", 32'(m_valid), 0);
        adv();
        settle();
        chk("t1_no_data_grant_cycle", 32'(m_valid), 0);
        adv();
        settle();
        chk("t1_first_valid", 32'(m_valid), 1);
        adv();
        for (int i = 0; i < 20 && (beats - b0) < 3; i++) begin
            settle();
            adv();
        end
        settle();
        chk("t1_rel_ack", 32'(arb_acknowledge), 1);
        chk("t1_rel_req", 32'(arb_request), 0);
        adv();
        settle();
        chk("t1_ack_single", 32'(arb_acknowledge), 0);
        adv();
        run_idle(20, "t1_idle");
        chk("t1_beats", 32'(beats - b0), 3);
        chk("t1_ack_count", 32'(acks - a0), 1);
        settle();
        chk("t1_req_after", 32'(arb_request), 0);
        chk("t1_busy_after", 32'(busy), 0);
        adv();

        // Queue fills behind a burst stuck waiting for grant
        arb_dly = 1;
        arb_block = 1'b1;
        upd_grant();
        b0 = beats;
        push_cmd(2);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            ok = arb_request;
            adv();
            if (ok) break;
        end
        chk("t2_req_raised", 32'(ok), 1);
        push_cmd(1);
        push_cmd(2);
        push_cmd(1);
        push_cmd(2);
        settle();
        chk("t2_full_ready", 32'(cmd_ready), 0);
        adv();
        cmd_valid = 1'b1;
        cmd_len   = LW'(3);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t2_fifth_stall", 32'(cmd_ready), 0);
            adv();
        end
        arb_block = 1'b0;
        upd_grant();
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            settle();
            ok = pushed;
            adv();
            if (ok) break;
        end
        cmd_valid = 1'b0;
        chk("t2_fifth_accepted", 32'(ok), 1);
        chk("t2_fifth_after_first", 32'(beats - b0), 2);
        run_idle(300, "t2_idle");
        chk("t2_beats", 32'(beats - b0), 11);

        // len=5 with m_ready toggling
        toggle_ready = 1'b1;
        b0 = beats;
        push_cmd(5);
        run_idle(100, "t3_idle");
        toggle_ready = 1'b0;
        m_ready = 1'b1;
        chk("t3_beats", 32'(beats - b0), 5);

        // len=4, grant withdrawn after two beats for three cycles
        b0 = beats;
        push_cmd(4);
        for (int i = 0; i < 30 && (beats - b0) < 2; i++) begin
            settle();
            adv();
        end
        arb_block = 1'b1;
        upd_grant();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_ungranted_valid", 32'(m_valid), 0);
            chk("t4_ungranted_sready", 32'(s_ready), 0);
            chk("t4_ungranted_req", 32'(arb_request), 1);
            adv();
        end
        chk("t4_beats_paused", 32'(beats - b0), 2);
        arb_block = 1'b0;
        upd_grant();
        run_idle(40, "t4_idle");
        chk("t4_beats", 32'(beats - b0), 4);

        // Zero-length command is dropped, then a single beat
        b0 = beats;
        a0 = acks;
        saw_req = 1'b0;
        push_cmd(0);
        repeat (4) adv();
        settle();
        chk("t5_zero_no_req", 32'(saw_req), 0);
        chk("t5_zero_busy", 32'(busy), 0);
        adv();
        push_cmd(1);
        run_idle(30, "t5_idle");
        chk("t5_beats", 32'(beats - b0), 1);
        chk("t5_acks", 32'(acks - a0), 1);

        // Reset mid-burst with rem=3 and two commands queued
        arb_block = 1'b1;
        upd_grant();
        push_cmd(5);
        push_cmd(2);
        push_cmd(2);
        arb_block = 1'b0;
        upd_grant();
        b0 = beats;
        for (int i = 0; i < 30 && (beats - b0) < 2; i++) begin
            settle();
            adv();
        end
        m_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(arb_request), 0);
        chk("t6_rst_ack", 32'(arb_acknowledge), 0);
        chk("t6_rst_m_valid", 32'(m_valid), 0);
        chk("t6_rst_m_last", 32'(m_last), 0);
        chk("t6_rst_s_ready", 32'(s_ready), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        repeat (3) adv();
        exp_q.delete();
        exp_idx = src_idx;
        rst_n   = 1'b1;
        m_ready = 1'b1;
        saw_req = 1'b0;
        repeat (6) adv();
        settle();
        chk("t6_queue_empty", 32'(busy), 0);
        chk("t6_cmd_ready", 32'(cmd_ready), 1);
        chk("t6_no_req", 32'(saw_req), 0);
        adv();
        b0 = beats;
        push_cmd(2);
        run_idle(30, "t6_idle");
        chk("t6_beats", 32'(beats - b0), 2);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
Name: arb_requester

Overview:
- Requester-side agent for the shared-resource arbiter. It queues burst commands from a local master, raises request, and waits for its grant bit.
- While granted, it gates a payload stream onto the shared bus for exactly the commanded beat count, then releases the grant.
- Release is either an acknowledge pulse or a request deassert, matching the arbiter's blocking mode.
- One instance sits per arbiter port, between a local master and the arbiter/shared-bus mux.

Parameters:
- DATA_WIDTH, 32, payload width.
- MAX_BURST, 16, maximum beats per command.
- DEPTH, 4, command queue entries (power of two, ≥2).
- ARB_BLOCK_ACK, 1: 1 = release by one-cycle arb_acknowledge pulse; 0 = release by deasserting arb_request.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid&&ready.
- cmd_len  in  $clog2(MAX_BURST+1)  beats in burst, 0..MAX_BURST.
- s_data  in  DATA_WIDTH  payload from local master.
- s_valid  in  1  payload valid.
- s_ready  out  1  payload accepted.
- m_data  out  DATA_WIDTH  payload to shared bus.
- m_valid  out  1  bus beat valid.
- m_ready  in  1  bus accepts beat.
- m_last  out  1  final beat of burst.
- arb_request  out  1  request to arbiter.
- arb_grant  in  1  this port's grant bit from arbiter (registered there).
- arb_acknowledge  out  1  release pulse (ARB_BLOCK_ACK=1 only; otherwise tied 0).
- busy  out  1  state != IDLE or queue non-empty.

Behaviour:
- Reset (async assert, sync deassert internally) forces:
  - arb_request=0, arb_acknowledge=0, m_valid=0, m_last=0, s_ready=0, busy=0.
  - Queue empty; cmd_ready=1 once reset is released.
- Command queue:
  - DEPTH-entry FIFO of lengths; cmd_ready = !full.
  - Simultaneous push and pop when full is not allowed, because ready is low.
  - Simultaneous push and pop otherwise keeps the count unchanged.
- FSM IDLE/REQ/XFER/RELEASE; remaining-beat counter rem.
- IDLE: if the queue is non-empty, pop the head.
  - len=0: discard it, stay in IDLE, no request issued.
  - Otherwise rem=len and go to REQ next cycle.
- REQ: arb_request=1. On arb_grant=1, go to XFER. No payload moves in REQ.
- XFER: arb_request=1.
  - m_valid=s_valid, s_ready=m_ready, m_data=s_data (combinational passthrough).
  - m_last=(rem==1). A beat occurs on m_valid&&m_ready, and rem decrements.
  - A beat with rem==1 goes to RELEASE.
- Grant lost in XFER (arb_grant=0 before the last beat, non-blocking arbiter):
  - m_valid=s_ready=0 in that same cycle.
  - Return to REQ with rem preserved; no beat is counted that cycle.
- RELEASE: arb_request=0.
  - If ARB_BLOCK_ACK=1, arb_acknowledge=1 for exactly the first RELEASE cycle.
  - Stay until arb_grant=0, then IDLE. This prevents a stale grant being taken for a new burst.
- Latency:
  - Queue non-empty to arb_request high: 1 cycle.
  - arb_grant high to first m_valid: 1 cycle.
  - Back-to-back bursts need ≥1 IDLE cycle between RELEASE exit and the next REQ.
- Commands accepted during XFER/RELEASE queue normally and never alter the active burst.
- Reset mid-burst drops all queued commands and the in-flight beat count. Outputs return to reset values immediately.

Test Plan:
- One command len=3; arbiter grants 2 cycles after request; m_ready=1, s_valid=1.
  - Required: 3 beats D0..D2 with m_last on D2.
  - Required: arb_acknowledge pulses once, then arb_request=0 and busy=0.
- Four commands pushed back-to-back with DEPTH=4 and grant withheld.
  - Required: cmd_ready drops after the 4th push.
  - Required: the 5th cmd_valid stalls until the first burst leaves the queue.
- len=5 burst with m_ready toggling 1,0,1,0…
  - Required: exactly 5 beats, data in order, m_last only on the 5th accepted beat.
- len=4; arb_grant dropped after beat 2 and regranted 3 cycles later.
  - Required: m_valid=0 while ungranted, arb_request stays 1, exactly 2 more beats are sent.
- cmd_len=0 followed by len=1.
  - Required: the zero command produces no request.
  - Required: the len=1 burst completes normally.
- Assert rst_n=0 mid-XFER with rem=3 and 2 commands queued.
  - Required: all outputs return to reset values asynchronously.
  - Required: the queue is empty after release, and there is no request until a new command arrives.
